// File: rtl/lcd_text_feeder.sv
// HD44780 byte source: power-up wait, init commands, then full 2x16 redraws of a
// host-written character buffer, offered to the pin driver over valid/ready.
module lcd_text_feeder #(
   parameter int POWERUP_CYCLES    = 750000,
   parameter int CLEAR_WAIT_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh,
   output logic       busy,
   output logic [7:0] lcd_byte,
   output logic       lcd_rs,
   output logic       lcd_valid,
   input  logic       lcd_ready
);

   localparam int CNT_MAX = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_POWERUP = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_CLRWAIT = 3'd2;
   localparam logic [2:0] S_IDLE    = 3'd3;
   localparam logic [2:0] S_ADDR0   = 3'd4;
   localparam logic [2:0] S_LINE0   = 3'd5;
   localparam logic [2:0] S_ADDR1   = 3'd6;
   localparam logic [2:0] S_LINE1   = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    idx_q, idx_d;
   logic [7:0]    byte_q, byte_d;
   logic          rs_q, rs_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          pending_q, pending_d;
   logic [7:0]    buf_q [32];

   logic          xfer;
   logic          start_redraw;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h06;
         default: init_cmd = 8'h01;
      endcase
   endfunction

   assign xfer = valid_q & lcd_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      byte_d       = byte_q;
      rs_d         = rs_q;
      valid_d      = valid_q;
      start_redraw = 1'b0;

      case (state_q)
         S_POWERUP: begin
            if (cnt_q == CW'(POWERUP_CYCLES)) begin
               state_d = S_INIT;
               cnt_d   = '0;
               idx_d   = 5'd0;
               byte_d  = init_cmd(2'd0);
               rs_d    = 1'b0;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_INIT: begin
            if (xfer) begin
               if (idx_q == 5'd3) begin
                  state_d = S_CLRWAIT;
                  cnt_d   = '0;
                  valid_d = 1'b0;
               end else begin
                  idx_d  = idx_q + 5'd1;
                  byte_d = init_cmd(idx_d[1:0]);
               end
            end
         end
         S_CLRWAIT: begin
            // Leave one cycle early: the IDLE cycle completes the clear wait.
            if (int'(cnt_q) + 2 >= CLEAR_WAIT_CYCLES) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_IDLE: begin
            if (pending_q) begin
               start_redraw = 1'b1;
               state_d      = S_ADDR0;
               byte_d       = 8'h80;
               rs_d         = 1'b0;
               valid_d      = 1'b1;
            end
         end
         S_ADDR0: begin
            if (xfer) begin
               state_d = S_LINE0;
               idx_d   = 5'd0;
               byte_d  = buf_q[0];
               rs_d    = 1'b1;
            end
         end
         S_LINE0: begin
            if (xfer) begin
               if (idx_q == 5'd15) begin
                  state_d = S_ADDR1;
                  byte_d  = 8'hC0;
                  rs_d    = 1'b0;
               end else begin
                  idx_d  = idx_q + 5'd1;
                  byte_d = buf_q[idx_d];
               end
            end
         end
         S_ADDR1: begin
            if (xfer) begin
               state_d = S_LINE1;
               idx_d   = 5'd16;
               byte_d  = buf_q[16];
               rs_d    = 1'b1;
            end
         end
         default: begin
            if (xfer) begin
               if (idx_q == 5'd31) begin
                  // A pending change chains straight into the next redraw without idling.
                  if (pending_q) begin
                     start_redraw = 1'b1;
                     state_d      = S_ADDR0;
                     byte_d       = 8'h80;
                     rs_d         = 1'b0;
                     valid_d      = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     valid_d = 1'b0;
                  end
               end else begin
                  idx_d  = idx_q + 5'd1;
                  byte_d = buf_q[idx_d];
               end
            end
         end
      endcase

      pending_d = wr_en | refresh | (pending_q & ~start_redraw);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_POWERUP;
         cnt_q     <= '0;
         idx_q     <= 5'd0;
         byte_q    <= 8'h00;
         rs_q      <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b1;
         pending_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         byte_q    <= byte_d;
         rs_q      <= rs_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         pending_q <= pending_d;
      end
   end

   // Loads above read the pre-write value when a write hits the same address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            buf_q[i] <= 8'h20;
         end
      end else if (wr_en) begin
         buf_q[wr_addr] <= wr_data;
      end
   end

   assign busy      = busy_q;
   assign lcd_byte  = byte_q;
   assign lcd_rs    = rs_q;
   assign lcd_valid = valid_q;

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Scoreboard bench for lcd_text_feeder: expected {rs,byte} pushed by stimulus,
// popped and compared by a monitor on every accepted transfer.
module tb_lcd_text_feeder;

   localparam int P = 10;
   localparam int C = 5;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       refresh;
   logic       busy;
   logic [7:0] lcd_byte;
   logic       lcd_rs;
   logic       lcd_valid;
   logic       lcd_ready;

   lcd_text_feeder #(
      .POWERUP_CYCLES   (P),
      .CLEAR_WAIT_CYCLES(C)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .refresh  (refresh),
      .busy     (busy),
      .lcd_byte (lcd_byte),
      .lcd_rs   (lcd_rs),
      .lcd_valid(lcd_valid),
      .lcd_ready(lcd_ready)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         xfer_cnt = 0;
   int         ready_mode = 1;   // 0 low, 1 high, 2 random 30% high
   logic [8:0] exp_q[$];
   int         xfer_cyc[$];
   logic [7:0] tb_buf[32];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      lcd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0)      lcd_ready = 1'b0;
         else if (ready_mode == 1) lcd_ready = 1'b1;
         else                      lcd_ready = ($urandom_range(0, 99) < 30);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: compares each accepted byte against the scoreboard and checks stall stability.
   initial begin
      logic       stall_prev;
      logic [8:0] held;
      logic [8:0] e;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev)
               check("stall_hold", {22'd0, lcd_valid, lcd_rs, lcd_byte}, {22'd0, 1'b1, held});
            if (lcd_valid && lcd_ready) begin
               xfer_cnt = xfer_cnt + 1;
               xfer_cyc.push_back(cyc);
               $display("xfer cyc=%0d rs=%0b byte=%02h", cyc, lcd_rs, lcd_byte);
               if (exp_q.size() == 0) begin
                  check("unexpected_xfer", {23'd0, lcd_rs, lcd_byte}, 32'h1FF);
               end else begin
                  e = exp_q.pop_front();
                  check("xfer_byte", {23'd0, lcd_rs, lcd_byte}, {23'd0, e});
               end
            end
            stall_prev = lcd_valid && !lcd_ready;
            held = {lcd_rs, lcd_byte};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_init();
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h006);
      exp_q.push_back(9'h001);
   endtask

   task automatic push_redraw();
      exp_q.push_back(9'h080);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, tb_buf[i]});
      exp_q.push_back(9'h0C0);
      for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, tb_buf[i]});
   endtask

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_quiet(input int budget, output int at_cyc);
      bit ok;
      ok = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            at_cyc = cyc;
         end
      end
      check("wait_quiet", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_xfers(input int n, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         if (xfer_cnt >= n) ok = 1'b1;
      end
      check("wait_xfers", {31'd0, ok}, 32'd1);
   endtask

   task automatic powerup_run(input string tag);
      int q;
      push_init();
      push_redraw();
      wait_quiet(300, q);
      check({tag, "_first_cmd_cyc"}, xfer_cyc[0], P + 1);
      check({tag, "_init_last_cyc"}, xfer_cyc[3], P + 4);
      check({tag, "_clrwait_gap"}, xfer_cyc[4] - xfer_cyc[3], C + 1);
      check({tag, "_redraw_span"}, xfer_cyc[37] - xfer_cyc[4], 33);
      check({tag, "_busy_fall"}, q, xfer_cyc[37] + 1);
      check({tag, "_xfer_total"}, xfer_cyc.size(), 38);
   endtask

   initial begin
      int base;
      int q;
      int k;
      rst = 1'b1;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      refresh = 1'b0;
      for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", {31'd0, lcd_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_byte", {24'd0, lcd_byte}, 32'd0);
      check("rst_rs", {31'd0, lcd_rs}, 32'd0);

      // Power-up and init, then the first blank redraw.
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      powerup_run("pwr");

      repeat (8) tick();
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_no_xfer", xfer_cnt, 38);

      // Idle writes: the second write coincides with the redraw start, so a follow-up redraw is owed.
      base = xfer_cnt;
      xfer_cyc.delete();
      tb_buf[0] = 8'h48;
      tb_buf[17] = 8'h69;
      push_redraw();
      push_redraw();
      host_write(5'd0, 8'h48);
      host_write(5'd17, 8'h69);
      wait_quiet(300, q);
      check("idlewr_count", xfer_cnt - base, 68);

      // Backpressure: same content, random ready.
      base = xfer_cnt;
      ready_mode = 2;
      push_redraw();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      wait_quiet(2000, q);
      ready_mode = 1;
      tick();
      check("bp_count", xfer_cnt - base, 34);

      // Mid-redraw writes: addr2 after 5th LINE0 byte, addr31 during LINE0.
      base = xfer_cnt;
      xfer_cyc.delete();
      tb_buf[31] = 8'h5A;
      push_redraw();
      tb_buf[2] = 8'h41;
      push_redraw();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      wait_xfers(base + 6, 50);
      tick();
      host_write(5'd2, 8'h41);
      host_write(5'd31, 8'h5A);
      wait_quiet(300, q);
      check("mid_count", xfer_cnt - base, 68);
      check("mid_no_gap", xfer_cyc[67] - xfer_cyc[0], 67);

      // Refresh alone: one redraw, 0x80 one cycle after pending sets.
      base = xfer_cnt;
      xfer_cyc.delete();
      push_redraw();
      refresh = 1'b1;
      k = cyc;
      tick();
      refresh = 1'b0;
      wait_quiet(300, q);
      repeat (10) tick();
      check("refresh_count", xfer_cnt - base, 34);
      check("refresh_latency", xfer_cyc[0], k + 2);

      // Refresh with a simultaneous write: exactly one redraw carrying the new byte.
      base = xfer_cnt;
      tb_buf[5] = 8'h33;
      push_redraw();
      refresh = 1'b1;
      wr_en = 1'b1;
      wr_addr = 5'd5;
      wr_data = 8'h33;
      tick();
      refresh = 1'b0;
      wr_en = 1'b0;
      wait_quiet(300, q);
      repeat (10) tick();
      check("refwr_count", xfer_cnt - base, 34);

      // Reset asserted between edges mid-LINE1 while stalled.
      base = xfer_cnt;
      push_redraw();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      wait_xfers(base + 20, 100);
      ready_mode = 0;
      @(posedge clk);
      @(posedge clk);
      #3;
      check("pre_rst_valid", {31'd0, lcd_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", {31'd0, lcd_valid}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd1);
      check("async_rst_byte", {24'd0, lcd_byte}, 32'd0);
      exp_q.delete();
      xfer_cyc.delete();
      for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
      ready_mode = 1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      powerup_run("rerst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
